// File: rtl/down_counter_ctrl_if.sv
// Control/status bundle for down_counter_ctrl: the master drives load/start/count_en,
// the counter (slave) returns the count value and status flags.
interface down_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             count_en;
    logic [WIDTH-1:0] q_out;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, count_en,
        input  q_out, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, count_en,
        output q_out, tc, busy, done
    );
endinterface

// File: rtl/down_counter_ctrl.sv
// Loadable down-counter with IDLE/RUN/DONE control FSM and registered terminal-count pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN for periodic mode (reload at terminal count instead of stopping).
module down_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    down_counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_next;
    logic             tc_reg;
    logic             tc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc_reg <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            reload <= reload_next;
            tc_reg <= tc_next;
        end
    end

    // Priority is load > start > count_en; tc defaults low so it is only ever a one-cycle pulse.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        tc_next     = 1'b0;

        if (bus.load) begin
            count_next  = bus.load_val;
            reload_next = bus.load_val;
            state_next  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (count != '0) begin
                            state_next = RUN;
                        end else begin
                            state_next = DONE;
                            tc_next    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.count_en) begin
                        if (count > ONE) begin
                            count_next = count - ONE;
                        end else if (count == ONE) begin
                            tc_next = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                            if (reload != '0) begin
                                count_next = reload;
                            end else begin
                                count_next = '0;
                                state_next = DONE;
                            end
`else
                            count_next = '0;
                            state_next = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    count_next = '0;
                    if (bus.start) begin
                        if (reload != '0) begin
                            count_next = reload;
                            state_next = RUN;
                        end else begin
                            tc_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign bus.q_out = count;
    assign bus.tc    = tc_reg;
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);

endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
Loadable, programmable down-counter with a small control FSM. It counts from a loaded value to zero and flags terminal count.
- Complements the team's up-counter; used as a timeout/interval timer alongside it.
- Single clock domain.
- Synchronous, active-high reset.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal range 2..16)

Ports:
clk       input   1      system clock; all state updates on rising edge
reset     input   1      synchronous, active-high reset, sampled on rising edge of clk
load      input   1      capture load_val into counter and reload register
load_val  input   WIDTH  value to load
start     input   1      begin/resume countdown (single-cycle pulse expected; level tolerated)
count_en  input   1      decrement qualifier while running (0 = pause)
q_out     output  WIDTH  current count value, registered
tc        output  1      terminal-count pulse, registered, 1 cycle wide
busy      output  1      high while FSM in RUN
done      output  1      high while FSM in DONE

Behaviour:
- Reset (reset=1 at rising clk edge):
  - q_out=0, reload register=0, tc=0, state=IDLE; busy=0, done=0.
  - Reset overrides all other inputs, including mid-count.
- States: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE), decoded from the state register with no extra latency.
- Priority each cycle: reset > load > start > count_en.
- load=1, any state: next q_out=load_val, reload register=load_val, state->IDLE, tc=0. Any start/count_en asserted in the same cycle is ignored.
- IDLE:
  - start=1 and q_out!=0 -> RUN next cycle. q_out is unchanged on that edge; the first decrement happens no earlier than the following cycle.
  - start=1 and q_out==0 -> DONE next cycle; tc=1 for that one cycle.
  - Otherwise hold.
- RUN:
  - count_en=1 and q_out>1 -> q_out decrements by 1.
  - count_en=1 and q_out==1 -> q_out=0, tc=1 on the same edge, state->DONE.
  - count_en=0 -> hold q_out and state (pause).
  - start while in RUN is ignored.
- DONE:
  - q_out holds 0, tc=0 after its single pulse.
  - start=1 -> q_out=reload register and state->RUN if reload!=0. If reload==0, stay DONE and pulse tc again.
  - count_en is ignored.
- No wrap-around below 0 under any input sequence; q_out never underflows.
- Width: decrement is WIDTH-bit unsigned. Maximum count 2^WIDTH-1 takes exactly that many enabled cycles to reach 0.
- Latency:
  - load to q_out visible: 1 cycle.
  - start to RUN: 1 cycle.
  - N enabled cycles in RUN from value N -> tc.

Optional Feature:
Macro: DOWN_COUNTER_AUTO_RELOAD_EN
- Defined: in RUN, count_en=1 with q_out==1 pulses tc, sets q_out=reload register, and stays in RUN (periodic mode).
  - DONE is entered only if reload==0.
  - The tc period is exactly reload enabled cycles.
- Undefined: behaviour exactly as above (one-shot: go to DONE at terminal count).

Test Plan:
- Assert reset 2 cycles with load=1, start=1 -> q_out=0, tc=0, busy=0, done=0 after release.
- load_val=5, load; start; count_en=1 continuously -> busy from cycle after start; q_out 5,4,3,2,1,0; tc=1 only on the edge q_out becomes 0; done=1 afterwards, q_out stays 0.
- load 3, start, count_en toggled 1,0,0,1,1 -> q_out 3,2,2,2,1,0; tc on the last edge; pauses do not advance.
- In RUN at q_out=2, assert load with load_val=9 and count_en=1 -> q_out=9, state IDLE, busy=0, no tc. Separately: reset mid-RUN -> q_out=0, IDLE.
- load 0, start -> DONE next cycle with single tc pulse; start again in DONE -> tc pulses again, stays DONE, q_out=0.
- With DOWN_COUNTER_AUTO_RELOAD_EN: load 3, start, count_en=1 for 10 cycles -> tc every 3rd enabled cycle; q_out sequence 3,2,1,3,2,1,...; busy stays 1, done stays 0.
